// File: rtl/iir_out_capture_pkg.sv
// Shared defaults and FSM encoding for the filter-output capture block.
package iir_out_capture_pkg;

  localparam int CAP_DATA_W = 24;
  localparam int CAP_ADDR_W = 11;
  localparam int CAP_DEPTH  = 2048;

  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_RUN  = 2'd1,
    CAP_DONE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/iir_out_capture_if.sv
// Sample stream, control, readback and status bundle between a host and iir_out_capture.
interface iir_out_capture_if
  import iir_out_capture_pkg::*;
#(
  parameter int DATA_W = CAP_DATA_W,
  parameter int ADDR_W = CAP_ADDR_W
);

  logic                     start;
  logic signed [DATA_W-1:0] data_in;
  logic                     data_in_valid;
  logic                     stable_in;
  logic                     rd_en;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic        [ADDR_W-1:0] wr_addr;
  logic                     capture_busy;
  logic                     capture_done;
  logic                     overflow;
  logic        [DATA_W-1:0] peak_abs;

  modport master (
    output start, data_in, data_in_valid, stable_in, rd_en, rd_addr,
    input  rd_data, rd_valid, wr_addr, capture_busy, capture_done, overflow, peak_abs
  );

  modport slave (
    input  start, data_in, data_in_valid, stable_in, rd_en, rd_addr,
    output rd_data, rd_valid, wr_addr, capture_busy, capture_done, overflow, peak_abs
  );

endinterface

// File: rtl/iir_out_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read-first read port.
module iir_cap_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or read register so this maps onto block RAM; the
  // non-blocking write makes a same-address read return the previous contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/iir_out_capture.sv
// Captures DEPTH filter output samples into RAM for readback; tracks peak |y| and overflow.
module iir_out_capture
  import iir_out_capture_pkg::*;
#(
  parameter int DATA_W      = CAP_DATA_W,
  parameter int ADDR_W      = CAP_ADDR_W,
  parameter int DEPTH       = CAP_DEPTH,
  parameter bit WAIT_STABLE = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  iir_out_capture_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS   = {1'b0, {(DATA_W-1){1'b1}}};

  cap_state_e        state;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [DATA_W-1:0] peak_q;

  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] abs_in;
  logic              wr_en;
  logic              last_wr;
  logic              rd_in_range;
  logic              ram_re;
  logic [DATA_W-1:0] ram_q;
  logic              rd_valid_q;
  logic              rd_zero_q;

  assign din = bus.data_in;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    wr_en = (state == CAP_RUN) && bus.data_in_valid && (bus.stable_in || !WAIT_STABLE)
            && !bus.start;
    last_wr = wr_en && (wr_addr_q == LAST_ADDR);
    if (!din[DATA_W-1])      abs_in = din;
    else if (din == MIN_NEG) abs_in = MAX_POS;
    else                     abs_in = -din;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CAP_IDLE;
      wr_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      peak_q    <= '0;
    end else if (bus.start) begin
      state     <= CAP_RUN;
      wr_addr_q <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      peak_q    <= '0;
    end else begin
      case (state)
        CAP_RUN: begin
          if (wr_en) begin
            if (abs_in > peak_q) peak_q <= abs_in;
            if (last_wr) begin
              wr_addr_q <= '0;
              done_q    <= 1'b1;
              busy_q    <= 1'b0;
              state     <= CAP_DONE;
            end else begin
              wr_addr_q <= wr_addr_q + 1'b1;
            end
          end
        end
        CAP_DONE: begin
          if (bus.data_in_valid) ovf_q <= 1'b1;
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

  // Out-of-range reads never touch the array; a registered flag forces the result to zero.
  assign rd_in_range = ({1'b0, bus.rd_addr} < (ADDR_W+1)'(DEPTH));
  assign ram_re      = bus.rd_en && rd_in_range;

  iir_cap_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr_q),
    .wdata (din),
    .re    (ram_re),
    .raddr (bus.rd_addr),
    .rdata (ram_q)
  );

  // rd_zero_q starts set so rd_data reads zero out of reset while the RAM itself stays unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_zero_q <= !rd_in_range;
    end
  end

  assign bus.rd_data      = rd_zero_q ? '0 : ram_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.capture_busy = busy_q;
  assign bus.capture_done = done_q;
  assign bus.overflow     = ovf_q;
  assign bus.peak_abs     = peak_q;

endmodule
